mem_access_scheduler: RTL

MEM_ACCESS_SCHEDULER -- requirements
Module: mem_access_scheduler

---
 rtl/mem_access_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler
//   Round-robin scheduler that lets NUM_CLIENTS requesters share one memory
//   port. Each transaction walks IDLE -> ISSUE -> WAIT -> DONE. The winning
//   client's command is latched on entry to ISSUE. After that point, changes
//   on req/wr/addr/wdata have no effect until the transaction finishes.
//
//   Optional feature: define MEM_SCHED_TIMEOUT_EN to bound WAIT to TIMEOUT
//   cycles. On expiry the transaction ends with done and err pulsing together.
//   Without the macro, WAIT waits indefinitely for mem_ack and err stays 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req, wr             per-client request / write flag
//   addr, wdata         per-client command, client i at slice i
//   gnt                 one-hot grant, held ISSUE..DONE
//   done                one-cycle completion pulse to the granted client
//   rdata               read data, registered on mem_ack
//   err                 one-cycle abort pulse (timeout build only)
//   mem_en              one-cycle memory strobe per transaction
//   mem_wr/addr/wdata   latched command of the granted client
//   mem_rdata, mem_ack  memory response
module mem_access_scheduler #(
  parameter int unsigned NUM_CLIENTS = 8,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS-1:0]            wr,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_CLIENTS-1:0]            gnt,
  output logic [NUM_CLIENTS-1:0]            done,
  output logic [DATA_WIDTH-1:0]             rdata,
  output logic                              err,
  output logic                              mem_en,
  output logic                              mem_wr,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  input  logic                              mem_ack
);

  localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last;
  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic               err_r;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_CLIENTS];

  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  // wait_cnt counts completed WAIT cycles. The block expires on the last one.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // Round-robin search. Candidates are checked in order starting at last+1,
  // wrapping past NUM_CLIENTS-1 back to 0, so last-granted is checked last.
  always_comb begin
    int unsigned      idx;
    logic [IDX_W-1:0] sel;
    pick_valid = 1'b0;
    pick       = last;
    idx        = 0;
    sel        = '0;
    for (int unsigned k = 1; k <= NUM_CLIENTS; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      sel = IDX_W'(idx);
      if (!pick_valid && req[sel]) begin
        pick_valid = 1'b1;
        pick       = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      done      <= '0;
      err_r     <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      last      <= IDX_W'(NUM_CLIENTS - 1);
`ifdef MEM_SCHED_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      // done, err and mem_en are single-cycle pulses.
      mem_en <= 1'b0;
      done   <= '0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state     <= ISSUE;
            last      <= pick;
            gnt       <= NUM_CLIENTS'(1) << pick;
            mem_en    <= 1'b1;
            mem_wr    <= wr[pick];
            mem_addr  <= addr_arr[pick];
            mem_wdata <= wdata_arr[pick];
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef MEM_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mem_ack) begin
            rdata <= mem_rdata;
            done  <= gnt;
            state <= DONE;
          end
`ifdef MEM_SCHED_TIMEOUT_EN
          else if (timed_out) begin
            done  <= gnt;
            err_r <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
          gnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // err_r is only ever set on the timeout path. Without the macro it stays 0.
  assign err = err_r;

endmodule
